// File: rtl/edge_detector_pkg.sv
// edge_detector_pkg
//   Shared definitions for the multi-channel edge detector: the per-channel
//   event-mode encoding used to qualify rise/fall pulses into events.
package edge_detector_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

endpackage

// File: rtl/edge_channel.sv
// edge_channel
//   One channel of the edge detector: synchroniser chain, stability filter,
//   registered rise/fall pulses, mode-qualified event, saturating event
//   counter and sticky pending flag.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_s            raw asynchronous input
//   mode            event mode (off / rise / fall / both)
//   cnt_clr         synchronous counter clear
//   pend_clr        pending flag clear
//   level_s         filtered level
//   rise_s, fall_s  one-cycle pulses on accepted transitions
//   evt_s           combinational mode-qualified event
//   cnt             saturating event count
//   pend            sticky pending flag
module edge_channel
  import edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_s,
  input  logic [1:0]       mode,
  input  logic             cnt_clr,
  input  logic             pend_clr,
  output logic             level_s,
  output logic             rise_s,
  output logic             fall_s,
  output logic             evt_s,
  output logic [CNT_W-1:0] cnt,
  output logic             pend
);

  localparam int STAB_W = $clog2(FILTER_LEN) + 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;
  logic [STAB_W-1:0]      stab_p1;
  mode_t                  mode_e;

  // Stage p0: synchroniser chain, oldest sample is the synchronised level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in_s};
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage p1: stability filter; a new level is accepted only after it has
  // differed from the current level on FILTER_LEN consecutive cycles, and the
  // pulse for it is registered alongside the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_s <= 1'b0;
      stab_p1 <= '0;
      rise_s  <= 1'b0;
      fall_s  <= 1'b0;
    end else begin
      rise_s <= 1'b0;
      fall_s <= 1'b0;
      if (s_p0 == level_s) begin
        stab_p1 <= '0;
      end else if (stab_p1 == STAB_LAST) begin
        level_s <= s_p0;
        stab_p1 <= '0;
        rise_s  <= s_p0;
        fall_s  <= ~s_p0;
      end else begin
        stab_p1 <= stab_p1 + 1'b1;
      end
    end
  end

  assign mode_e = mode_t'(mode);
  assign evt_s  = (rise_s & ((mode_e == MODE_RISE) | (mode_e == MODE_BOTH)))
                | (fall_s & ((mode_e == MODE_FALL) | (mode_e == MODE_BOTH)));

  // Stage p2: event bookkeeping; a clear coinciding with an event still
  // records that event, and a pending set wins over a pending clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= evt_s ? CNT_ONE : '0;
      end else if (evt_s && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if (evt_s) begin
        pend <= 1'b1;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/edge_detector_multi.sv
// edge_detector_multi
//   WIDTH independent filtered edge detectors with per-channel event mode,
//   saturating counters and sticky pending flags, plus a registered interrupt
//   that is the OR of all pending flags.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_s       raw asynchronous inputs, one per channel
//   mode       per-channel mode, channel i at [2i+1:2i]
//   level_s    filtered levels
//   rise_s     one-cycle pulses on accepted 0->1 transitions
//   fall_s     one-cycle pulses on accepted 1->0 transitions
//   evt_s      mode-qualified events (combinational)
//   cnt        event counts, channel i at [i*CNT_W +: CNT_W]
//   cnt_clr    per-channel counter clear
//   pend       sticky pending flags
//   pend_clr   per-channel pending clear
//   irq        registered OR of pend
module edge_detector_multi
  import edge_detector_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_s,
  input  logic [2*WIDTH-1:0]     mode,
  output logic [WIDTH-1:0]       level_s,
  output logic [WIDTH-1:0]       rise_s,
  output logic [WIDTH-1:0]       fall_s,
  output logic [WIDTH-1:0]       evt_s,
  output logic [WIDTH*CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0]       cnt_clr,
  output logic [WIDTH-1:0]       pend,
  input  logic [WIDTH-1:0]       pend_clr,
  output logic                   irq
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in_s    (in_s[i]),
      .mode    (mode[2*i +: 2]),
      .cnt_clr (cnt_clr[i]),
      .pend_clr(pend_clr[i]),
      .level_s (level_s[i]),
      .rise_s  (rise_s[i]),
      .fall_s  (fall_s[i]),
      .evt_s   (evt_s[i]),
      .cnt     (cnt[i*CNT_W +: CNT_W]),
      .pend    (pend[i])
    );
  end

  // Stage p3: interrupt trails the pending flags by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |pend;
    end
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
module tb_edge_detector_multi;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int FL = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    in_s;
  logic [2*W-1:0]  mode;
  logic [W-1:0]    level_s, rise_s, fall_s, evt_s, pend, cnt_clr, pend_clr;
  logic [W*CW-1:0] cnt;
  logic            irq;

  edge_detector_multi #(
    .WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_s(in_s), .mode(mode),
    .level_s(level_s), .rise_s(rise_s), .fall_s(fall_s), .evt_s(evt_s),
    .cnt(cnt), .cnt_clr(cnt_clr), .pend(pend), .pend_clr(pend_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: synchronised value is the input seen SS edges ago; a new
  // level is accepted on the FL-th consecutive edge where it differs.
  bit m_hist [W][SS];
  bit m_lvl  [W];
  bit m_rise [W];
  bit m_fall [W];
  bit m_pend [W];
  int m_run  [W];
  int m_cnt  [W];
  bit m_irq;

  typedef struct { int cyc; int ch; bit dir; } pev_t;
  pev_t pq[$];

  always @(posedge clk) begin
    bit anyp;
    cyc++;
    if (rst) begin
      for (int c = 0; c < W; c++) begin
        for (int j = 0; j < SS; j++) m_hist[c][j] = 1'b0;
        m_lvl[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
        m_pend[c] = 0; m_run[c] = 0; m_cnt[c] = 0;
      end
      m_irq = 0;
    end else begin
      anyp = 0;
      for (int c = 0; c < W; c++) anyp |= m_pend[c];
      for (int c = 0; c < W; c++) begin
        bit ev;
        bit s;
        ev = (m_rise[c] && mode[2*c]) || (m_fall[c] && mode[2*c+1]);
        if (cnt_clr[c]) m_cnt[c] = ev ? 1 : 0;
        else if (ev && m_cnt[c] < CMAX) m_cnt[c]++;
        if (ev) m_pend[c] = 1;
        else if (pend_clr[c]) m_pend[c] = 0;
        s = m_hist[c][SS-1];
        m_rise[c] = 0;
        m_fall[c] = 0;
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == FL) begin
            m_lvl[c] = s;
            m_rise[c] = s;
            m_fall[c] = !s;
            m_run[c] = 0;
            pq.push_back('{cyc: cyc, ch: c, dir: s});
          end
        end else begin
          m_run[c] = 0;
        end
        for (int j = SS - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
        m_hist[c][0] = in_s[c];
      end
      m_irq = anyp;
    end
  end

  // Monitor: pops expected pulses whenever the DUT shows one, and compares
  // the observable channel state every cycle.
  always @(posedge clk) begin
    logic [W-1:0]    elvl, epend, eevt;
    logic [W*CW-1:0] ecnt;
    pev_t e;
    #2;
    for (int c = 0; c < W; c++) begin
      if (rise_s[c] || fall_s[c]) begin
        if (pq.size() == 0) begin
          chk("pulse_unexpected", {rise_s[c], fall_s[c]}, 2'b00);
        end else begin
          e = pq.pop_front();
          chk("pulse", {32'(e.cyc), 8'(e.ch), rise_s[c], fall_s[c]},
                       {32'(cyc), 8'(c), e.dir, !e.dir});
        end
      end
    end
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      e = pq.pop_front();
      chk("pulse_missed", {8'(e.ch), 1'b0}, {8'(e.ch), 1'b1});
    end
    for (int c = 0; c < W; c++) begin
      elvl[c]  = m_lvl[c];
      epend[c] = m_pend[c];
      eevt[c]  = (m_rise[c] && mode[2*c]) || (m_fall[c] && mode[2*c+1]);
      ecnt[c*CW +: CW] = CW'(m_cnt[c]);
    end
    chk("level", level_s, elvl);
    chk("cnt", cnt, ecnt);
    chk("pend_irq", {pend, irq}, {epend, m_irq});
    chk("evt", evt_s, eevt);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    return cnt[c*CW +: CW];
  endfunction

  initial begin
    int exp_sweep [4] = '{0, 1, 1, 2};
    rst = 1'b1; in_s = '0; mode = '0; cnt_clr = '0; pend_clr = '0;
    tick(3);
    chk("reset_outputs", {level_s, rise_s, fall_s, pend, irq}, '0);
    chk("reset_cnt", cnt, '0);
    rst = 1'b0;
    mode = 8'b11_00_11_01;
    tick(2);

    // Basic rise on channel 0 with its latency
    in_s[0] = 1'b1;
    tick(5);
    chk("rise_latency_early", {rise_s[0], level_s[0]}, 2'b00);
    tick(1);
    chk("rise_pulse", {rise_s[0], level_s[0]}, 2'b11);
    tick(1);
    chk("rise_single", rise_s[0], 1'b0);
    chk("cnt0_after_rise", cnt_of(0), 3'd1);
    chk("pend0_irq_lag", {pend[0], irq}, 2'b10);
    tick(1);
    chk("irq_set", irq, 1'b1);

    // Short glitch on channel 1 is filtered out
    in_s[1] = 1'b1; tick(2); in_s[1] = 1'b0; tick(10);
    chk("glitch_level", level_s[1], 1'b0);
    chk("glitch_cnt", cnt_of(1), 3'd0);

    // Mode sweep on channel 2
    for (int m = 0; m < 4; m++) begin
      mode[5:4] = 2'(m);
      cnt_clr[2] = 1'b1; tick(1); cnt_clr[2] = 1'b0;
      in_s[2] = 1'b1; tick(8);
      in_s[2] = 1'b0; tick(8);
      chk("mode_sweep_cnt", {2'(m), cnt_of(2)}, {2'(m), 3'(exp_sweep[m])});
    end

    // Saturation and clear behaviour on channel 3
    for (int k = 0; k < 9; k++) begin
      in_s[3] = ~in_s[3]; tick(7);
    end
    chk("sat_cnt", cnt_of(3), 3'd7);
    in_s[3] = 1'b0; tick(6);
    chk("sat_fall_pulse", fall_s[3], 1'b1);
    cnt_clr[3] = 1'b1; tick(1); cnt_clr[3] = 1'b0;
    chk("clr_with_evt", cnt_of(3), 3'd1);
    cnt_clr[3] = 1'b1; tick(1); cnt_clr[3] = 1'b0;
    chk("clr_alone", cnt_of(3), 3'd0);

    // Pending clear interactions
    pend_clr = '1; tick(1); pend_clr = '0;
    chk("pend_all_clr", pend, '0);
    tick(1);
    chk("irq_cleared", irq, 1'b0);
    mode[1:0] = 2'b11;
    in_s[0] = 1'b0; tick(6);
    chk("pend_fall_pulse", fall_s[0], 1'b1);
    pend_clr[0] = 1'b1; tick(1); pend_clr[0] = 1'b0;
    chk("pend_set_wins", pend[0], 1'b1);
    pend_clr[0] = 1'b1; tick(1); pend_clr[0] = 1'b0;
    chk("pend_clr_alone", pend[0], 1'b0);
    tick(1);
    chk("irq_after_clr", irq, 1'b0);

    // Reset mid-filter and mid-pulse
    in_s[1] = 1'b1; tick(3);
    rst = 1'b1; tick(1);
    chk("rst_mid_filter", {level_s, rise_s, fall_s, pend, irq, cnt}, '0);
    rst = 1'b0;
    tick(5);
    chk("post_rst_early", rise_s[1], 1'b0);
    tick(1);
    chk("post_rst_rise", {rise_s[1], level_s[1]}, 2'b11);
    rst = 1'b1; tick(1);
    chk("rst_mid_pulse", {level_s, rise_s, fall_s, pend, irq, cnt}, '0);
    rst = 1'b0;
    tick(5);
    chk("rerelease_early", rise_s[1], 1'b0);
    tick(1);
    chk("rerelease_rise", rise_s[1], 1'b1);
    tick(1);
    chk("rerelease_single", {rise_s[1], level_s[1]}, 2'b01);

    // Randomised traffic against the model
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 5) == 0) in_s[c] = ~in_s[c];
        if ($urandom_range(0, 60) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
        cnt_clr[c]  = ($urandom_range(0, 25) == 0);
        pend_clr[c] = ($urandom_range(0, 10) == 0);
      end
      rst = ($urandom_range(0, 400) == 0);
      tick(1);
    end
    rst = 1'b0; cnt_clr = '0; pend_clr = '0;
    tick(12);
    chk("pulse_queue_empty", 64'(pq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
